n24k16_burst_bist: RTL
======================

# n24k16_burst_bist

Built-in self-test controller for the (24,16) burst-error-correcting encoder/decoder pair; corrects bursts of length up to 3. It drives a message into the combinational encoder and XORs every burst pattern of length 3 onto every window of the codeword. Each corrupted word goes to the combinational decoder, and the controller compares the decoded message with the original. Sits beside the encoder/decoder instances and gives a single pass/fail summary to the system test controller.

## Interface
- CW_W, 24, codeword width
- MSG_W, 16, message width
- BURST_L, 3, burst length swept
- FAIL_CNT_W, 8, width of saturating failure counter
- clk  input  1  sole clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a sweep; sampled in IDLE or DONE only
- abort  input  1  synchronous: stop sweep, return to IDLE
- msg_seed  input  MSG_W  message captured at start
- enc_msg  output  [0:MSG_W-1]  message to encoder (registered)
- enc_cw  input  [0:CW_W-1]  encoder output
- dec_cw  output  [0:CW_W-1]  corrupted codeword to decoder (registered)
- dec_msg  input  [0:MSG_W-1]  decoder output
- busy  output  1  sweep in progress
- done  output  1  sweep complete; held until next start/abort
- pass  output  1  valid with done; 1 iff fail_cnt==0
- fail_cnt  output  FAIL_CNT_W  mismatching vectors, saturating
- first_fail_pos  output  5  window start of first failing vector
- first_fail_pat  output  BURST_L  pattern of first failing vector

## Operation
- Reset: state IDLE; every output 0, including enc_msg, dec_cw, and first_fail_*.
- States:
  - IDLE --start--> APPLY.
  - APPLY -> CHECK.
  - CHECK -> APPLY, or DONE after the last vector.
  - DONE --start--> APPLY.
  - Any state --abort--> IDLE.
  - abort has priority over start.
- On start:
  - enc_msg <= msg_seed.
  - pos=0, pat=0.
  - fail_cnt and first_fail_* cleared; a sticky first-fail flag cleared.
  - done=0.
- Vector order: pat inner 0..2^BURST_L-1, pos outer 0..CW_W-BURST_L (22 positions). Total 176 vectors. pat=0 is the error-free vector.
- Error mask bit mapping: pat[BURST_L-1] -> codeword[pos], pat[BURST_L-2] -> codeword[pos+1], ..., pat[0] -> codeword[pos+BURST_L-1]. Codeword index 0 is the MSB, ascending.
- APPLY: dec_cw <= enc_cw ^ mask(pos,pat).
- CHECK: mismatch = (dec_msg != enc_msg).
  - On mismatch: fail_cnt increments unless it is all-ones.
  - On the first mismatch only: latch first_fail_pos and first_fail_pat.
  - Then advance pat/pos.
- start while busy: ignored.
- abort in DONE: clears done. Result registers keep their values until the next start.
- dec_cw keeps its last value in IDLE/DONE.

## Timing
- Cycle 0: start sampled.
- Vector k (0..175): APPLY in cycle 1+2k, CHECK in cycle 2+2k.
- busy=1 from cycle 1 through cycle 352.
- Cycle 353: done=1, busy=0, pass valid.
- dec_msg is sampled in CHECK, one cycle after dec_cw updates. The external encoder+decoder combinational path must settle within one clk period.
- rst_n low at any time: immediate return to reset values; no done pulse.
- abort: IDLE on the next edge with busy=0, done=0; a new start is accepted the cycle after.

## Configuration
- BIST_MSG_LFSR_EN defined:
  - After each position's last pattern, enc_msg advances through a 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1.
  - An all-zero seed is replaced with 16'hACE1 at start.
  - The sweep takes the same 353 cycles.
- Undefined: enc_msg holds msg_seed for the whole sweep.

## Test plan
- Reference encoder/decoder, msg_seed=16'hFFFF, start pulse:
  - done at cycle 353, pass=1, fail_cnt=0.
  - busy high for exactly 352 cycles.
- Decoder model forced to output ~enc_msg:
  - fail_cnt=176, pass=0.
  - first_fail_pos=0, first_fail_pat=0.
- Decoder model wrong only when dec_cw differs from enc_cw exactly at bits 21 and 23 (pos=21, pat=3'b101):
  - fail_cnt=1, first_fail_pos=21, first_fail_pat=5.
- start re-pulsed at cycle 100: ignored, done still at cycle 353. abort at cycle 150: busy=0 and done=0 at cycle 151.
- rst_n low at cycle 200: all outputs 0 asynchronously. A start after reset release gives a full clean sweep with pass=1.
- With BIST_MSG_LFSR_EN, msg_seed=0:
  - enc_msg=16'hACE1 for pos 0.
  - enc_msg changes at the first APPLY of pos 1.
  - pass=1.

Source files
------------

// File: rtl/n24k16_burst_bist.sv
// n24k16_burst_bist: self-test controller for the (24,16) burst-error-correcting
// encoder/decoder pair. Each burst pattern of length BURST_L is XORed onto each window
// of the codeword. The decoded message is then compared with the original, and the
// result is a pass/fail summary.
// Optional feature: define BIST_MSG_LFSR_EN to step the message through a 16-bit LFSR
// after every window position.
module n24k16_burst_bist #(
    parameter int unsigned CW_W       = 24,
    parameter int unsigned MSG_W      = 16,
    parameter int unsigned BURST_L    = 3,
    parameter int unsigned FAIL_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [MSG_W-1:0]      msg_seed_i,
    output logic [0:MSG_W-1]      enc_msg_o,
    input  logic [0:CW_W-1]       enc_cw_i,
    output logic [0:CW_W-1]       dec_cw_o,
    input  logic [0:MSG_W-1]      dec_msg_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic [FAIL_CNT_W-1:0] fail_cnt_o,
    output logic [4:0]            first_fail_pos_o,
    output logic [BURST_L-1:0]    first_fail_pat_o
);

    localparam int unsigned PosW = 5;
    localparam logic [PosW-1:0] PosLast = PosW'(CW_W - BURST_L);

    typedef enum logic [1:0] {StIdle, StApply, StCheck, StDone} state_e;

    state_e                  state_q, state_d;
    logic [0:MSG_W-1]        enc_msg_q, enc_msg_d;
    logic [0:CW_W-1]         dec_cw_q, dec_cw_d;
    logic [PosW-1:0]         pos_q, pos_d;
    logic [BURST_L-1:0]      pat_q, pat_d;
    logic [FAIL_CNT_W-1:0]   fail_cnt_q, fail_cnt_d;
    logic [PosW-1:0]         ff_pos_q, ff_pos_d;
    logic [BURST_L-1:0]      ff_pat_q, ff_pat_d;
    logic                    ff_seen_q, ff_seen_d;

    logic [0:CW_W-1]         mask;
    logic [MSG_W-1:0]        seed_eff;
    logic                    last_pat;
    logic                    last_vec;
    logic                    mismatch;

    // Pattern MSB lands on codeword index pos (index 0 is the codeword MSB).
    assign mask     = {pat_q, {(CW_W - BURST_L){1'b0}}} >> pos_q;
    assign last_pat = (pat_q == '1);
    assign last_vec = last_pat && (pos_q == PosLast);
    assign mismatch = (dec_msg_i != enc_msg_q);

`ifdef BIST_MSG_LFSR_EN
    logic [MSG_W-1:0] lfsr_cur;
    logic [MSG_W-1:0] lfsr_nxt;

    // Fibonacci LFSR, x^16+x^14+x^13+x^11+1; an all-zero seed would lock up.
    always_comb begin
        lfsr_cur = enc_msg_q;
        lfsr_nxt = {lfsr_cur[0] ^ lfsr_cur[2] ^ lfsr_cur[3] ^ lfsr_cur[5], lfsr_cur[MSG_W-1:1]};
        seed_eff = (msg_seed_i == '0) ? MSG_W'(16'hACE1) : msg_seed_i;
    end
`else
    assign seed_eff = msg_seed_i;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort wins over everything, including start.
    always_comb begin
        state_d = state_q;
        if (abort_i) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle:  if (start_i) state_d = StApply;
                StApply: state_d = StCheck;
                StCheck: state_d = last_vec ? StDone : StApply;
                StDone:  if (start_i) state_d = StApply;
                default: state_d = StIdle;
            endcase
        end
    end

    // Status outputs decoded from the state.
    always_comb begin
        busy_o = 1'b0;
        done_o = 1'b0;
        pass_o = 1'b0;
        case (state_q)
            StApply, StCheck: busy_o = 1'b1;
            StDone: begin
                done_o = 1'b1;
                pass_o = (fail_cnt_q == '0);
            end
            default: ;
        endcase
    end

    // Datapath next state: vector sequencing, corruption and result capture.
    always_comb begin
        enc_msg_d  = enc_msg_q;
        dec_cw_d   = dec_cw_q;
        pos_d      = pos_q;
        pat_d      = pat_q;
        fail_cnt_d = fail_cnt_q;
        ff_pos_d   = ff_pos_q;
        ff_pat_d   = ff_pat_q;
        ff_seen_d  = ff_seen_q;
        if (!abort_i) begin
            case (state_q)
                StIdle, StDone: begin
                    if (start_i) begin
                        enc_msg_d  = seed_eff;
                        pos_d      = '0;
                        pat_d      = '0;
                        fail_cnt_d = '0;
                        ff_pos_d   = '0;
                        ff_pat_d   = '0;
                        ff_seen_d  = 1'b0;
                    end
                end
                StApply: dec_cw_d = enc_cw_i ^ mask;
                StCheck: begin
                    if (mismatch) begin
                        if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + FAIL_CNT_W'(1);
                        if (!ff_seen_q) begin
                            ff_pos_d  = pos_q;
                            ff_pat_d  = pat_q;
                            ff_seen_d = 1'b1;
                        end
                    end
                    if (last_pat) begin
                        pat_d = '0;
                        if (!last_vec) begin
                            pos_d = pos_q + PosW'(1);
`ifdef BIST_MSG_LFSR_EN
                            enc_msg_d = lfsr_nxt;
`endif
                        end
                    end else begin
                        pat_d = pat_q + BURST_L'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_msg_q  <= '0;
            dec_cw_q   <= '0;
            pos_q      <= '0;
            pat_q      <= '0;
            fail_cnt_q <= '0;
            ff_pos_q   <= '0;
            ff_pat_q   <= '0;
            ff_seen_q  <= 1'b0;
        end else begin
            enc_msg_q  <= enc_msg_d;
            dec_cw_q   <= dec_cw_d;
            pos_q      <= pos_d;
            pat_q      <= pat_d;
            fail_cnt_q <= fail_cnt_d;
            ff_pos_q   <= ff_pos_d;
            ff_pat_q   <= ff_pat_d;
            ff_seen_q  <= ff_seen_d;
        end
    end

    assign enc_msg_o        = enc_msg_q;
    assign dec_cw_o         = dec_cw_q;
    assign fail_cnt_o       = fail_cnt_q;
    assign first_fail_pos_o = ff_pos_q;
    assign first_fail_pat_o = ff_pat_q;

endmodule
